qspi_target: RTL and testbench

SPI mode-3 target (responder) for the single/quad SPI link driven by the team's SPI initiator. Oversamples the external SCLK, CS and SIO lines in the system clock domain. Decodes a one-byte command, then either delivers received data bytes to the fabric or shifts out fabric-supplied bytes. Sits at the chip boundary as the peripheral-side counterpart of the initiator, and doubles as the bench's bus-functional responder.

---
 rtl/qspi_target.sv | 233 +++++++++++++++++++++++
 tb/tb_qspi_target.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_target.sv
`default_nettype none
// ============================================================================
// Module   : qspi_target
// Brief    : SPI mode-3 target with oversampled SCLK/CS/SIO; one command byte,
//            then write bytes to the fabric or read bytes from it. Quad opcodes
//            are built only when QSPI_TARGET_QUAD_EN is defined.
// Revision : 1.0
// ============================================================================

module qspi_target #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_sclk,
    input  logic       i_cs,
    inout  wire  [3:0] SIO,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_load,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic [7:0] o_cmd,
    output logic       o_cmd_valid,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

`ifdef QSPI_TARGET_QUAD_EN
    localparam int c_SIO_W = 4;
`else
    localparam int c_SIO_W = 1;
`endif

    typedef enum logic [2:0] {
`ifdef QSPI_TARGET_QUAD_EN
        S_WR_Q   = 3'd3,
        S_RD_Q   = 3'd5,
`endif
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_WR_S   = 3'd2,
        S_RD_S   = 3'd4,
        S_IGNORE = 3'd6
    } state_t;

    logic [SYNC_STAGES-1:0]              r_sclk_sync;
    logic [SYNC_STAGES-1:0]              r_cs_sync;
    logic [SYNC_STAGES-1:0]              r_fill;
    logic [SYNC_STAGES-1:0][c_SIO_W-1:0] r_sio_sync;
    logic                                r_sclk_prev;
    logic                                r_cs_prev;
    logic                                r_armed;

    logic               w_sclk_s;
    logic               w_cs_s;
    logic [c_SIO_W-1:0] w_sio_s;
    logic               w_rise;
    logic               w_fall;
    logic               w_cs_rise;
    logic               w_cs_fall;

    state_t      r_state;
    state_t      w_state_nxt;
    state_t      w_decode;
    logic        w_decode_rd;
    logic [7:0]  w_byte_s;
    logic [7:0]  r_shift;
    logic [2:0]  r_cnt;
    logic [3:0]  r_oe;
    logic [3:0]  r_so;

    // Synchronizers reset to the idle bus levels; r_fill marks when the CS
    // chain holds real pin samples so a CS held low through reset is not
    // mistaken for a fresh falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sclk_sync <= '1;
            r_cs_sync   <= '1;
            r_sio_sync  <= '0;
            r_fill      <= '0;
            r_sclk_prev <= 1'b1;
            r_cs_prev   <= 1'b1;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
            r_sio_sync  <= {r_sio_sync[SYNC_STAGES-2:0], SIO[c_SIO_W-1:0]};
            r_fill      <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_sclk_prev <= w_sclk_s;
            r_cs_prev   <= w_cs_s;
            r_armed     <= r_armed | (r_fill[SYNC_STAGES-1] & w_cs_s);
        end
    end

    assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
    assign w_sio_s   = r_sio_sync[SYNC_STAGES-1];
    assign w_rise    = w_sclk_s & ~r_sclk_prev;
    assign w_fall    = ~w_sclk_s & r_sclk_prev;
    assign w_cs_rise = w_cs_s & ~r_cs_prev;
    assign w_cs_fall = ~w_cs_s & r_cs_prev & r_armed;

    always_comb begin
        w_byte_s = {r_shift[6:0], w_sio_s[0]};
        case (w_byte_s)
            8'h02:   w_decode = S_WR_S;
            8'h03:   w_decode = S_RD_S;
`ifdef QSPI_TARGET_QUAD_EN
            8'h32:   w_decode = S_WR_Q;
            8'h6B:   w_decode = S_RD_Q;
`endif
            default: w_decode = S_IGNORE;
        endcase

        w_state_nxt = r_state;
        if (w_cs_rise) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_cs_fall) w_state_nxt = S_CMD;
                S_CMD:   if (w_rise && r_cnt == 3'd7) w_state_nxt = w_decode;
                default: ;
            endcase
        end
    end

`ifdef QSPI_TARGET_QUAD_EN
    assign w_decode_rd = (w_decode == S_RD_S) || (w_decode == S_RD_Q);
`else
    assign w_decode_rd = (w_decode == S_RD_S);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_cnt       <= '0;
            r_oe        <= '0;
            r_so        <= '0;
            o_rx_data   <= '0;
            o_cmd       <= '0;
            o_rx_valid  <= 1'b0;
            o_cmd_valid <= 1'b0;
            o_tx_load   <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_rx_valid  <= 1'b0;
            o_cmd_valid <= 1'b0;
            o_tx_load   <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            // SCLK phases are long enough that no edge lands on the load cycle.
            if (o_tx_load) r_shift <= i_tx_data;
            if (w_cs_rise) begin
                r_cnt  <= '0;
                r_oe   <= '0;
                o_done <= (r_state != S_IDLE);
            end else begin
                case (r_state)
                    S_CMD: if (w_rise) begin
                        r_shift <= w_byte_s;
                        r_cnt   <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            o_cmd       <= w_byte_s;
                            o_cmd_valid <= 1'b1;
                            o_err       <= (w_decode == S_IGNORE);
                            o_tx_load   <= w_decode_rd;
                        end
                    end
                    S_WR_S: if (w_rise) begin
                        r_shift <= w_byte_s;
                        r_cnt   <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            o_rx_data  <= w_byte_s;
                            o_rx_valid <= 1'b1;
                        end
                    end
                    S_RD_S: begin
                        if (w_fall) begin
                            r_so[1] <= r_shift[7];
                            r_shift <= {r_shift[6:0], 1'b0};
                            r_oe    <= 4'b0010;
                        end
                        if (w_rise) begin
                            r_cnt <= r_cnt + 3'd1;
                            if (r_cnt == 3'd7) o_tx_load <= 1'b1;
                        end
                    end
`ifdef QSPI_TARGET_QUAD_EN
                    S_WR_Q: if (w_rise) begin
                        r_shift <= {r_shift[3:0], w_sio_s};
                        r_cnt   <= (r_cnt == 3'd1) ? 3'd0 : r_cnt + 3'd1;
                        if (r_cnt == 3'd1) begin
                            o_rx_data  <= {r_shift[3:0], w_sio_s};
                            o_rx_valid <= 1'b1;
                        end
                    end
                    S_RD_Q: begin
                        if (w_fall) begin
                            r_so    <= r_shift[7:4];
                            r_shift <= {r_shift[3:0], 4'h0};
                            r_oe    <= 4'b1111;
                        end
                        if (w_rise) begin
                            r_cnt <= (r_cnt == 3'd1) ? 3'd0 : r_cnt + 3'd1;
                            if (r_cnt == 3'd1) o_tx_load <= 1'b1;
                        end
                    end
`endif
                    default: begin
                        r_cnt <= '0;
                        r_oe  <= '0;
                    end
                endcase
            end
        end
    end

    assign o_busy = (r_state != S_IDLE);

    for (genvar gi = 0; gi < 4; gi++) begin : g_sio
        assign SIO[gi] = r_oe[gi] ? r_so[gi] : 1'bz;
    end

endmodule

`default_nettype wire

// File: tb/tb_qspi_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_qspi_target
// Brief    : Directed bench for qspi_target acting as the SPI initiator, with
//            queued expected command/write/read bytes and event counts.
// Revision : 1.0
// ============================================================================

module tb_qspi_target;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b1;
    logic       cs = 1'b1;
    logic [3:0] tb_oe = 4'h0;
    logic [3:0] tb_out = 4'h0;
    logic [7:0] tx_data = 8'h00;
    wire  [3:0] sio;

    logic       tx_load, rx_valid, cmd_valid, busy, done, err;
    logic [7:0] rx_data, cmd;

    int n_checks = 0;
    int n_pass = 0;
    int cnt_done = 0;
    int cnt_err = 0;
    int cnt_load = 0;
    logic [7:0] exp_cmd[$];
    logic [7:0] exp_rx[$];
    logic [7:0] exp_rd[$];

    assign sio[0] = tb_oe[0] ? tb_out[0] : 1'bz;
    assign sio[1] = tb_oe[1] ? tb_out[1] : 1'bz;
    assign sio[2] = tb_oe[2] ? tb_out[2] : 1'bz;
    assign sio[3] = tb_oe[3] ? tb_out[3] : 1'bz;
    pullup (sio[0]);
    pullup (sio[1]);
    pullup (sio[2]);
    pullup (sio[3]);

    qspi_target #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_sclk     (sclk),
        .i_cs       (cs),
        .SIO        (sio),
        .i_tx_data  (tx_data),
        .o_tx_load  (tx_load),
        .o_rx_data  (rx_data),
        .o_rx_valid (rx_valid),
        .o_cmd      (cmd),
        .o_cmd_valid(cmd_valid),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Output monitor: pops the scoreboard whenever the DUT reports a byte.
    always @(negedge clk) begin
        if (done)    cnt_done++;
        if (err)     cnt_err++;
        if (tx_load) cnt_load++;
        if (cmd_valid) begin
            chk("cmd_expected", exp_cmd.size() != 0, 1);
            if (exp_cmd.size() != 0) chk("cmd_value", cmd, exp_cmd.pop_front());
        end
        if (rx_valid) begin
            chk("rx_expected", exp_rx.size() != 0, 1);
            if (exp_rx.size() != 0) chk("rx_value", rx_data, exp_rx.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit_s(input logic mosi, output logic miso);
        sclk = 1'b0;
        tb_out[0] = mosi;
        tick(HALF);
        miso = sio[1];
        sclk = 1'b1;
        tick(HALF);
    endtask

    task automatic spi_byte_s(input logic [7:0] mosi, output logic [7:0] miso);
        for (int i = 7; i >= 0; i--) spi_bit_s(mosi[i], miso[i]);
    endtask

    task automatic spi_nib(input logic [3:0] d, output logic [3:0] q);
        sclk = 1'b0;
        tb_out = d;
        tick(HALF);
        q = sio;
        sclk = 1'b1;
        tick(HALF);
    endtask

    task automatic cs_begin(input logic [3:0] oe);
        tb_oe  = oe;
        tb_out = 4'h0;
        cs     = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_end();
        cs = 1'b1;
        tb_oe = 4'h0;
        tick(2 * HALF);
    endtask

    initial begin
        #1_000_000;
        n_checks++;
        $error("FAIL watchdog: observed timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        logic [7:0] rb;
        logic [3:0] nh, nl;
        int d0, e0, l0;

        rst_n = 1'b0;
        tick(5);
        rst_n = 1'b1;
        tick(1);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_cmd", cmd, 8'h00);
        chk("rst_flags", {tx_load, rx_valid, cmd_valid, busy, done, err}, 6'b0);
        chk("rst_sio", sio, 4'hF);

        // Single write 0x02, 0xA5, 0x3C
        d0 = cnt_done; e0 = cnt_err; l0 = cnt_load;
        exp_cmd.push_back(8'h02);
        exp_rx.push_back(8'hA5);
        exp_rx.push_back(8'h3C);
        cs_begin(4'b0001);
        spi_byte_s(8'h02, rb);
        chk("wr_busy", busy, 1);
        spi_byte_s(8'hA5, rb);
        spi_byte_s(8'h3C, rb);
        cs_end();
        chk("wr_rx_data", rx_data, 8'h3C);
        chk("wr_done", cnt_done - d0, 1);
        chk("wr_err", cnt_err - e0, 0);
        chk("wr_load", cnt_load - l0, 0);
        chk("wr_busy_end", busy, 0);

        // Single read 0x03 returning 0x5A, 0xC3
        d0 = cnt_done; l0 = cnt_load;
        tx_data = 8'h5A;
        exp_cmd.push_back(8'h03);
        exp_rd.push_back(8'h5A);
        exp_rd.push_back(8'hC3);
        cs_begin(4'b0001);
        spi_byte_s(8'h03, rb);
        tx_data = 8'hC3;
        spi_byte_s(8'hFF, rb);
        chk("rd_byte0", rb, exp_rd.pop_front());
        spi_byte_s(8'hFF, rb);
        chk("rd_byte1", rb, exp_rd.pop_front());
        cs_end();
        chk("rd_load", cnt_load - l0, 3);
        chk("rd_done", cnt_done - d0, 1);
        chk("rd_sio_idle", sio, 4'hF);

        // Quad opcodes
        d0 = cnt_done; e0 = cnt_err; l0 = cnt_load;
        exp_cmd.push_back(8'h32);
`ifdef QSPI_TARGET_QUAD_EN
        exp_rx.push_back(8'h9E);
`endif
        cs_begin(4'b0001);
        spi_byte_s(8'h32, rb);
        tb_oe = 4'hF;
        spi_nib(4'h9, nh);
        spi_nib(4'hE, nl);
        cs_end();
        tx_data = 8'h7E;
        exp_cmd.push_back(8'h6B);
        cs_begin(4'b0001);
        spi_byte_s(8'h6B, rb);
        tb_oe = 4'h0;
        spi_nib(4'h0, nh);
        spi_nib(4'h0, nl);
        cs_end();
`ifdef QSPI_TARGET_QUAD_EN
        chk("qrd_hi", nh, 4'h7);
        chk("qrd_lo", nl, 4'hE);
        chk("q_rx_data", rx_data, 8'h9E);
        chk("q_err", cnt_err - e0, 0);
        chk("q_load", cnt_load - l0, 2);
`else
        chk("qoff_hi", nh, 4'hF);
        chk("qoff_lo", nl, 4'hF);
        chk("qoff_err", cnt_err - e0, 2);
        chk("qoff_load", cnt_load - l0, 0);
`endif
        chk("q_done", cnt_done - d0, 2);

        // Unsupported opcode 0x55 with two trailing bytes
        d0 = cnt_done; e0 = cnt_err; l0 = cnt_load;
        tx_data = 8'h00;
        exp_cmd.push_back(8'h55);
        cs_begin(4'b0001);
        spi_byte_s(8'h55, rb);
        spi_byte_s(8'h12, rb);
        chk("ign_so_b0", rb, 8'hFF);
        spi_byte_s(8'h34, rb);
        chk("ign_so_b1", rb, 8'hFF);
        chk("ign_sio_hi", sio[3:1], 3'b111);
        cs_end();
        chk("ign_err", cnt_err - e0, 1);
        chk("ign_done", cnt_done - d0, 1);
        chk("ign_load", cnt_load - l0, 0);

        // Abort after 4 bits of a write byte, then a clean write
        d0 = cnt_done;
        exp_cmd.push_back(8'h02);
        cs_begin(4'b0001);
        spi_byte_s(8'h02, rb);
        spi_bit_s(1'b1, rb[0]);
        spi_bit_s(1'b0, rb[0]);
        spi_bit_s(1'b1, rb[0]);
        spi_bit_s(1'b1, rb[0]);
        cs_end();
        chk("abort_done", cnt_done - d0, 1);
        exp_cmd.push_back(8'h02);
        exp_rx.push_back(8'h11);
        cs_begin(4'b0001);
        spi_byte_s(8'h02, rb);
        spi_byte_s(8'h11, rb);
        cs_end();
        chk("abort_next_rx", rx_data, 8'h11);

        // Reset in the middle of a single read
        tx_data = 8'h00;
        exp_cmd.push_back(8'h03);
        cs_begin(4'b0001);
        spi_byte_s(8'h03, rb);
        spi_bit_s(1'b1, rb[0]);
        spi_bit_s(1'b1, rb[0]);
        spi_bit_s(1'b1, rb[0]);
        chk("mr_so_driven", sio[1], 1'b0);
        d0 = cnt_done;
        rst_n = 1'b0;
        tick(1);
        chk("mr_sio", sio, 4'hF);
        chk("mr_cmd", cmd, 8'h00);
        chk("mr_flags", {tx_load, rx_valid, cmd_valid, busy, done, err}, 6'b0);
        tick(3);
        rst_n = 1'b1;
        tick(20);
        chk("mr_busy_cs_low", busy, 0);
        cs = 1'b1;
        tb_oe = 4'h0;
        tick(20);
        chk("mr_no_done", cnt_done - d0, 0);
        chk("mr_busy_idle", busy, 0);
        tx_data = 8'hA6;
        exp_cmd.push_back(8'h03);
        exp_rd.push_back(8'hA6);
        cs_begin(4'b0001);
        spi_byte_s(8'h03, rb);
        spi_byte_s(8'hFF, rb);
        chk("mr_read", rb, exp_rd.pop_front());
        cs_end();
        chk("mr_done_after", cnt_done - d0, 1);

        chk("sb_cmd_empty", exp_cmd.size(), 0);
        chk("sb_rx_empty", exp_rx.size(), 0);
        chk("sb_rd_empty", exp_rd.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
